// File: rtl/driver_cntrl_mc.sv
// ---------------------------------------------------------------------------
// driver_cntrl_mc
//   Multi-channel driver control/status register block. A 32-bit slave bus is
//   decoded into NUM_CH independent channel banks (address-FIFO feed, program
//   control, thresholds, status, sticky errors), a global interrupt/trace
//   window and per-channel monitor-counter windows. Each channel runs a small
//   program FSM (IDLE/ACTIVE/DONE/ERROR) driven by bus commands and FIFO
//   fault flags.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   slave_addr/rd/wr/data_in   byte-addressed single-cycle bus access
//   slave_data_out/rd_valid    registered read data, valid one cycle after rd
//   addr_fifo_din/wr           per-channel address FIFO write port
//   addr_fifo_*/vector_fifo_*  per-channel FIFO flags (fault sources, almost full)
//   words_in_*_fifo            per-channel FIFO occupancies (status readback)
//   *_fifo_threshold           per-channel programmable thresholds
//   run/end_program            one-cycle command strobes per channel
//   active_program             per-channel FSM-in-ACTIVE indication
//   mon_cnts                   monitor counters, channel-major, read-only window
//   trace_buf_bram_addr/data   trace buffer read address / wide read data
//   irq                        level interrupt = |(irq_pending & irq_en)
// ---------------------------------------------------------------------------
module driver_cntrl_mc #(
    parameter int          NUM_CH       = 2,
    parameter int          TRACE_W      = 256,
    parameter int          MON_CNT_NUM  = 16,
    parameter int          MON_CNT_SIZE = 16,
    parameter logic [15:0] ADDR_THR_RST = 16'd820,
    parameter logic [15:0] VCTR_THR_RST = 16'd7500
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [31:0]                               slave_addr,
    input  logic                                      slave_rd,
    input  logic                                      slave_wr,
    input  logic [31:0]                               slave_data_in,
    output logic [31:0]                               slave_data_out,
    output logic                                      slave_rd_valid,
    output logic [NUM_CH*32-1:0]                      addr_fifo_din,
    output logic [NUM_CH-1:0]                         addr_fifo_wr,
    input  logic [NUM_CH-1:0]                         addr_fifo_almost_full,
    input  logic [NUM_CH-1:0]                         addr_fifo_overrun,
    input  logic [NUM_CH-1:0]                         addr_fifo_underrun,
    input  logic [NUM_CH-1:0]                         vector_fifo_overrun,
    input  logic [NUM_CH-1:0]                         vector_fifo_underrun,
    input  logic [NUM_CH*16-1:0]                      words_in_addr_fifo,
    input  logic [NUM_CH*16-1:0]                      words_in_vctr_fifo,
    output logic [NUM_CH*16-1:0]                      addr_fifo_threshold,
    output logic [NUM_CH*16-1:0]                      vector_fifo_threshold,
    output logic [NUM_CH-1:0]                         run_program,
    output logic [NUM_CH-1:0]                         end_program,
    output logic [NUM_CH-1:0]                         active_program,
    input  logic [NUM_CH*MON_CNT_NUM*MON_CNT_SIZE-1:0] mon_cnts,
    output logic [31:0]                               trace_buf_bram_addr,
    input  logic [TRACE_W-1:0]                        trace_buf_bram_data,
    output logic                                      irq
);

    localparam int TRACE_WORDS = TRACE_W / 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    // Global registers
    logic [NUM_CH-1:0]    irq_en_reg;
    logic [31:0]          trace_addr_reg;
    logic [31:0]          rd_data_reg;
    logic [31:0]          rd_data_next;
    logic                 rd_valid_reg;
    logic [NUM_CH-1:0]    irq_pending;
    logic [NUM_CH*32-1:0] ch_rd_flat;

    logic wr_irq_en;
    logic wr_trace_addr;

    assign wr_irq_en     = slave_wr && (slave_addr == 32'h0000_8000);
    assign wr_trace_addr = slave_wr && (slave_addr == 32'h0000_8100);

    // -----------------------------------------------------------------------
    // Per-channel register bank and program FSM
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t      state_reg;
            state_t      state_next;
            logic        freeze_reg;
            logic        drop_reg;
            logic        fault_reg;
            logic        done_reg;
            logic [15:0] athr_reg;
            logic [15:0] vthr_reg;
            logic [31:0] din_reg;
            logic        fifo_wr_reg;
            logic        run_reg;
            logic        end_reg;
            logic [31:0] ch_rd;

            logic ch_sel;
            logic wr_fifo, wr_ctrl, wr_athr, wr_vthr, wr_err;
            logic run_cmd, end_cmd, abort_cmd;
            logic fifo_fault, fault_event, drop_event, done_event;

            // Channel gi owns the 4 KiB page starting at gi*0x1000.
            assign ch_sel    = (slave_addr[31:12] == 20'(gi));
            assign wr_fifo   = slave_wr && ch_sel && (slave_addr[11:0] == 12'h000);
            assign wr_ctrl   = slave_wr && ch_sel && (slave_addr[11:0] == 12'h004);
            assign wr_athr   = slave_wr && ch_sel && (slave_addr[11:0] == 12'h008);
            assign wr_vthr   = slave_wr && ch_sel && (slave_addr[11:0] == 12'h00C);
            assign wr_err    = slave_wr && ch_sel && (slave_addr[11:0] == 12'h014);

            assign run_cmd   = wr_ctrl && slave_data_in[0];
            assign end_cmd   = wr_ctrl && slave_data_in[1];
            assign abort_cmd = wr_ctrl && slave_data_in[2];

            assign fifo_fault = addr_fifo_overrun[gi]   | addr_fifo_underrun[gi] |
                                vector_fifo_overrun[gi] | vector_fifo_underrun[gi];

            // FIFO flags only count as a fault while a program is running.
            assign fault_event = (state_reg == ST_ACTIVE) && fifo_fault;
            assign drop_event  = wr_fifo && (freeze_reg || addr_fifo_almost_full[gi]);
            assign done_event  = (state_reg == ST_ACTIVE) && (state_next == ST_DONE);

            // Next-state logic; in ACTIVE a fault beats abort, abort beats end.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_IDLE:   if (run_cmd) state_next = ST_ACTIVE;
                    ST_ACTIVE: begin
                        if (fifo_fault)     state_next = ST_ERROR;
                        else if (abort_cmd) state_next = ST_IDLE;
                        else if (end_cmd)   state_next = ST_DONE;
                    end
                    ST_DONE:   if (run_cmd) state_next = ST_ACTIVE;
                    // Leaves ERROR once software has cleared the fault sticky.
                    ST_ERROR:  if (!fault_reg) state_next = ST_IDLE;
                    default:   state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg   <= ST_IDLE;
                    freeze_reg  <= 1'b0;
                    drop_reg    <= 1'b0;
                    fault_reg   <= 1'b0;
                    done_reg    <= 1'b0;
                    athr_reg    <= ADDR_THR_RST;
                    vthr_reg    <= VCTR_THR_RST;
                    din_reg     <= 32'h0;
                    fifo_wr_reg <= 1'b0;
                    run_reg     <= 1'b0;
                    end_reg     <= 1'b0;
                end else begin
                    state_reg   <= state_next;
                    run_reg     <= run_cmd;
                    end_reg     <= end_cmd;
                    fifo_wr_reg <= wr_fifo && !drop_event;
                    if (wr_fifo && !drop_event) din_reg <= slave_data_in;
                    if (wr_ctrl) freeze_reg <= slave_data_in[3];
                    if (wr_athr) athr_reg <= slave_data_in[15:0];
                    if (wr_vthr) vthr_reg <= slave_data_in[15:0];

                    // Sticky bits: a new event in the same cycle as W1C wins.
                    if (fault_event)                         fault_reg <= 1'b1;
                    else if (wr_err && slave_data_in[0])     fault_reg <= 1'b0;
                    if (drop_event)                          drop_reg  <= 1'b1;
                    else if (wr_err && slave_data_in[1])     drop_reg  <= 1'b0;
                    if (done_event)                          done_reg  <= 1'b1;
                    else if (run_cmd)                        done_reg  <= 1'b0;
                end
            end

            always_comb begin
                ch_rd = 32'h0;
                if (ch_sel) begin
                    case (slave_addr[11:0])
                        12'h004: ch_rd = {28'h0, freeze_reg, 3'b000};
                        12'h008: ch_rd = {16'h0, athr_reg};
                        12'h00C: ch_rd = {16'h0, vthr_reg};
                        12'h010: ch_rd = {28'h0, state_reg, drop_reg, fault_reg};
                        12'h014: ch_rd = {30'h0, drop_reg, fault_reg};
                        12'h018: ch_rd = {words_in_vctr_fifo[gi*16 +: 16],
                                          words_in_addr_fifo[gi*16 +: 16]};
                        default: ch_rd = 32'h0;
                    endcase
                end
            end

            assign ch_rd_flat[gi*32 +: 32]            = ch_rd;
            assign irq_pending[gi]                    = fault_reg | drop_reg | done_reg;
            assign addr_fifo_din[gi*32 +: 32]         = din_reg;
            assign addr_fifo_wr[gi]                   = fifo_wr_reg;
            assign addr_fifo_threshold[gi*16 +: 16]   = athr_reg;
            assign vector_fifo_threshold[gi*16 +: 16] = vthr_reg;
            assign run_program[gi]                    = run_reg;
            assign end_program[gi]                    = end_reg;
            assign active_program[gi]                 = (state_reg == ST_ACTIVE);
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read mux: built from current register values so a same-cycle write to
    // the same address returns the pre-write contents.
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data_next = 32'h0;
        for (int c = 0; c < NUM_CH; c++) begin
            rd_data_next = rd_data_next | ch_rd_flat[c*32 +: 32];
        end
        if (slave_addr == 32'h0000_8000) rd_data_next = 32'(irq_en_reg);
        if (slave_addr == 32'h0000_8004) rd_data_next = 32'(irq_pending);
        if (slave_addr == 32'h0000_8100) rd_data_next = trace_addr_reg;
        for (int k = 0; k < TRACE_WORDS; k++) begin
            if (slave_addr == 32'h0000_8110 + 32'(4 * k)) begin
                rd_data_next = trace_buf_bram_data[k*32 +: 32];
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < MON_CNT_NUM; i++) begin
                if (slave_addr == 32'h0000_9000 + 32'(c * 256 + 4 * i)) begin
                    rd_data_next = 32'(mon_cnts[(c*MON_CNT_NUM + i)*MON_CNT_SIZE +: MON_CNT_SIZE]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_reg     <= '0;
            trace_addr_reg <= 32'h0;
            rd_data_reg    <= 32'h0;
            rd_valid_reg   <= 1'b0;
        end else begin
            rd_valid_reg <= slave_rd;
            if (slave_rd) rd_data_reg <= rd_data_next;
            if (wr_irq_en) irq_en_reg <= slave_data_in[NUM_CH-1:0];
            if (wr_trace_addr) trace_addr_reg <= slave_data_in;
        end
    end

    assign slave_data_out      = rd_data_reg;
    assign slave_rd_valid      = rd_valid_reg;
    assign trace_buf_bram_addr = trace_addr_reg;
    assign irq                 = |(irq_pending & irq_en_reg);

endmodule
